// File: rtl/locked_adder_key_checker.sv
// Self-test sequencer for the XOR-key-locked 16-bit adder: drives a fixed vector set,
// checks each result against a golden sum and reports pass/fail statistics.
module locked_adder_key_checker #(
   parameter int          WIDTH     = 16,
   parameter int          KEY_W     = 32,
   parameter int          NUM_VEC   = 16,
   parameter int          SETTLE    = 2,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   localparam int         FCW       = $clog2(NUM_VEC+1),
   localparam int         IW        = $clog2(NUM_VEC),
   localparam int         CW        = (SETTLE > 1) ? $clog2(SETTLE) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [KEY_W-1:0] key_i,
   input  logic [WIDTH:0]   result_i,
   output logic [WIDTH-1:0] add1_o,
   output logic [WIDTH-1:0] add2_o,
   output logic [KEY_W-1:0] keyinput_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [FCW-1:0]   fail_count_o,
   output logic [IW-1:0]    first_fail_idx_o
);

   typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

   state_t           r_state;
   logic [IW-1:0]    r_idx;
   logic [CW-1:0]    r_cnt;
   logic [15:0]      r_lfsr;
   logic [WIDTH-1:0] r_a, r_b;
   logic [KEY_W-1:0] r_key;
   logic             r_busy, r_done, r_pass;
   logic [FCW-1:0]   r_fail;
   logic [IW-1:0]    r_ffi;

   logic [WIDTH:0]   w_gold;
   logic             w_mis;
   logic [IW-1:0]    w_nidx;
   logic [15:0]      w_lfsr_nxt;
   logic [WIDTH-1:0] w_na, w_nb;

   assign w_gold     = {1'b0, r_a} + {1'b0, r_b};
   assign w_mis      = (result_i != w_gold);
   assign w_nidx     = r_idx + 1'b1;
   assign w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

   // Operands for the vector that follows the current one; the LFSR only advances for idx>=2.
   always_comb begin
      w_na = '0;
      w_nb = '0;
      if (w_nidx == IW'(1)) begin
         w_na = '1;
         w_nb = WIDTH'(1);
      end else if (w_nidx != '0) begin
         w_na = WIDTH'(r_lfsr);
         w_nb = WIDTH'({r_lfsr[7:0], r_lfsr[15:8]});
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_lfsr  <= LFSR_SEED;
         r_a     <= '0;
         r_b     <= '0;
         r_key   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_fail  <= '0;
         r_ffi   <= '0;
      end else if (abort_i && (r_state == APPLY || r_state == CHECK)) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_lfsr  <= LFSR_SEED;
         r_a     <= '0;
         r_b     <= '0;
         r_key   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_fail  <= '0;
         r_ffi   <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start_i) begin
                  r_state <= APPLY;
                  r_key   <= key_i;
                  r_idx   <= '0;
                  r_cnt   <= '0;
                  r_lfsr  <= LFSR_SEED;
                  r_a     <= '0;
                  r_b     <= '0;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_pass  <= 1'b0;
                  r_fail  <= '0;
                  r_ffi   <= '0;
               end else if (r_state == DONE) begin
                  // Status is published one cycle after the last check, from the settled count.
                  r_done <= 1'b1;
                  r_pass <= (r_fail == '0);
               end
            end
            APPLY: begin
               if (r_cnt == CW'(SETTLE-1)) begin
                  r_cnt   <= '0;
                  r_state <= CHECK;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            CHECK: begin
               if (w_mis) begin
                  r_fail <= r_fail + 1'b1;
                  if (r_fail == '0) r_ffi <= r_idx;
               end
               if (r_idx == IW'(NUM_VEC-1)) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
               end else begin
                  r_idx   <= w_nidx;
                  r_a     <= w_na;
                  r_b     <= w_nb;
                  r_state <= APPLY;
                  if (w_nidx != '0 && w_nidx != IW'(1)) r_lfsr <= w_lfsr_nxt;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign add1_o           = r_a;
   assign add2_o           = r_b;
   assign keyinput_o       = r_key;
   assign busy_o           = r_busy;
   assign done_o           = r_done;
   assign pass_o           = r_pass;
   assign fail_count_o     = r_fail;
   assign first_fail_idx_o = r_ffi;

endmodule
